// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider: funct3 codes,
// register-bus widths, FSM state encoding and small datapath helpers.
package ex_div_pkg;

    localparam int REG_W      = 64;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 7;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [CNT_W-1:0] STEPS_WORD   = 7'd32;
    localparam logic [CNT_W-1:0] STEPS_DOUBLE = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_ZERO = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    function automatic logic [REG_W-1:0] sext32(input logic [31:0] v);
        return {{(REG_W-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for RV64IM DIV/REM and their W variants.
// Works on operand magnitudes and applies the RISC-V sign rules when finishing.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic                  word_i,
    input  logic [XLEN-1:0]       dividend_i,
    input  logic [XLEN-1:0]       divisor_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [XLEN-1:0]       result_o,
    output logic                  reg_we_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o
);

    div_state_e state_reg, state_next;

    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [XLEN-1:0]       quot_reg, quot_next;
    logic [XLEN-1:0]       rem_reg, rem_next;
    logic [XLEN-1:0]       divisor_reg, divisor_next;
    logic                  is_rem_reg, is_rem_next;
    logic                  word_reg, word_next;
    logic                  neg_q_reg, neg_q_next;
    logic                  neg_r_reg, neg_r_next;
    logic [REG_ADDR_W-1:0] rd_reg, rd_next;
    logic [XLEN-1:0]       result_reg, result_next;
    logic [REG_ADDR_W-1:0] waddr_reg, waddr_next;

    logic busy_c;
    logic ready_c;

    // Operand decode at acceptance time
    logic            is_signed;
    logic            is_rem;
    logic [XLEN-1:0] a_eff, b_eff;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            a_neg, b_neg, b_zero;

    always_comb begin
        is_signed = (op_i == INST_DIV) || (op_i == INST_REM);
        is_rem    = (op_i == INST_REM) || (op_i == INST_REMU);
        a_eff     = dividend_i;
        b_eff     = divisor_i;
        if (word_i) begin
            a_eff = is_signed ? sext32(dividend_i[31:0]) : {{(XLEN-32){1'b0}}, dividend_i[31:0]};
            b_eff = is_signed ? sext32(divisor_i[31:0])  : {{(XLEN-32){1'b0}}, divisor_i[31:0]};
        end
        a_neg  = is_signed && a_eff[XLEN-1];
        b_neg  = is_signed && b_eff[XLEN-1];
        a_mag  = a_neg ? -a_eff : a_eff;
        b_mag  = b_neg ? -b_eff : b_eff;
        b_zero = (b_eff == '0);
    end

    // One restoring step: shift {rem,quot} left, keep the subtraction if it did not borrow.
    // rem < divisor always holds, so the shifted value needs only one extra bit.
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem_reg, quot_reg[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor_reg};

    // Sign fix-up and word sign-extension of the finished quotient/remainder
    logic [XLEN-1:0] q_fix, r_fix, raw_res, final_res;

    always_comb begin
        q_fix     = neg_q_reg ? -quot_reg : quot_reg;
        r_fix     = neg_r_reg ? -rem_reg : rem_reg;
        raw_res   = is_rem_reg ? r_fix : q_fix;
        final_res = word_reg ? sext32(raw_res[31:0]) : raw_res;
    end

    logic [CNT_W-1:0] steps_total;
    assign steps_total = word_reg ? STEPS_WORD : STEPS_DOUBLE;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        quot_next    = quot_reg;
        rem_next     = rem_reg;
        divisor_next = divisor_reg;
        is_rem_next  = is_rem_reg;
        word_next    = word_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        rd_next      = rd_reg;
        result_next  = result_reg;
        waddr_next   = waddr_reg;
        busy_c       = 1'b0;
        ready_c      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy_c = start_i;
                if (start_i && !flush_i) begin
                    state_next   = b_zero ? ST_ZERO : ST_CALC;
                    cnt_next     = '0;
                    divisor_next = b_mag;
                    is_rem_next  = is_rem;
                    word_next    = word_i;
                    neg_q_next   = (a_neg ^ b_neg) && !b_zero;
                    neg_r_next   = a_neg;
                    rd_next      = reg_waddr_i;
                    if (b_zero) begin
                        // Divide by zero: quotient all ones, remainder is the dividend
                        quot_next = '1;
                        rem_next  = a_mag;
                    end else begin
                        // Word ops start with the 32-bit magnitude in the top half so
                        // that 32 steps shift it completely into the remainder.
                        quot_next = word_i ? {a_mag[31:0], 32'b0} : a_mag;
                        rem_next  = '0;
                    end
                end
            end
            ST_CALC: begin
                busy_c = 1'b1;
                if (cnt_reg == steps_total) begin
                    state_next  = ST_DONE;
                    result_next = final_res;
                    waddr_next  = rd_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (!trial[XLEN]) begin
                        rem_next  = trial[XLEN-1:0];
                        quot_next = {quot_reg[XLEN-2:0], 1'b1};
                    end else begin
                        rem_next  = shifted[XLEN-1:0];
                        quot_next = {quot_reg[XLEN-2:0], 1'b0};
                    end
                end
            end
            ST_ZERO: begin
                busy_c      = 1'b1;
                state_next  = ST_DONE;
                result_next = final_res;
                waddr_next  = rd_reg;
            end
            ST_DONE: begin
                busy_c     = 1'b1;
                ready_c    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A flushed operation must leave the visible result untouched.
        if (flush_i) begin
            state_next  = ST_IDLE;
            result_next = result_reg;
            waddr_next  = waddr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            is_rem_reg  <= 1'b0;
            word_reg    <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            rd_reg      <= '0;
            result_reg  <= '0;
            waddr_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
            divisor_reg <= divisor_next;
            is_rem_reg  <= is_rem_next;
            word_reg    <= word_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            rd_reg      <= rd_next;
            result_reg  <= result_next;
            waddr_reg   <= waddr_next;
        end
    end

    assign busy_o      = busy_c;
    assign ready_o     = ready_c;
    assign reg_we_o    = ready_c;
    assign result_o    = result_reg;
    assign reg_waddr_o = waddr_reg;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, hand-written flush/reset
// sequences, and randomized operations checked against an arithmetic reference model.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic        word_i;
    logic [63:0] dividend_i;
    logic [63:0] divisor_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [63:0] result_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;

    ex_div #(.XLEN(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .word_i      (word_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] last_res;
    logic [4:0]  last_rd;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [2:0] op, input logic word,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        vec_t v;
        v.name = nm; v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Reference: RISC-V M-extension semantics written with plain integer arithmetic
    function automatic logic [63:0] ref_div(input logic [2:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic        sgn, rem;
        longint      sa, sb, sq, sr;
        logic [31:0] ua32, ub32, uq32, ur32;
        logic [63:0] uq, ur, res;
        sgn = (op == 3'b100) || (op == 3'b110);
        rem = (op == 3'b110) || (op == 3'b111);
        res = '0;
        if (word) begin
            if (sgn) begin
                sa = longint'($signed(a[31:0]));
                sb = longint'($signed(b[31:0]));
                if (sb == 0) begin sq = -1; sr = sa; end
                else begin sq = sa / sb; sr = sa % sb; end
                res = rem ? sr : sq;
            end else begin
                ua32 = a[31:0];
                ub32 = b[31:0];
                if (ub32 == 0) begin uq32 = 32'hFFFF_FFFF; ur32 = ua32; end
                else begin uq32 = ua32 / ub32; ur32 = ua32 % ub32; end
                res = {32'b0, rem ? ur32 : uq32};
            end
            res = {{32{res[31]}}, res[31:0]};
        end else begin
            if (sgn) begin
                sa = a;
                sb = b;
                if (sb == 0) begin sq = -1; sr = sa; end
                else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                    sq = sa; sr = 0;
                end else begin sq = sa / sb; sr = sa % sb; end
                res = rem ? sr : sq;
            end else begin
                if (b == 0) begin uq = '1; ur = a; end
                else begin uq = a / b; ur = a % b; end
                res = rem ? ur : uq;
            end
        end
        return res;
    endfunction

    // Issue one operation, scramble the operands after acceptance, wait for ready.
    task automatic run_op(input string nm, input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp);
        int k;
        int busy_low;
        int lat;
        bit got;
        bit bz;
        bz  = word ? (b[31:0] == 32'b0) : (b == 64'b0);
        lat = bz ? 1 : (word ? 33 : 65);
        @(negedge clk);
        start_i     = 1'b1;
        op_i        = op;
        word_i      = word;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = rd;
        #1;
        chk({nm, "_busy_accept"}, 64'(busy_o), 64'd1);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        dividend_i  = {$urandom, $urandom};
        divisor_i   = {$urandom, $urandom};
        reg_waddr_i = 5'($urandom);
        op_i        = 3'($urandom);
        word_i      = 1'($urandom);
        k = 0; busy_low = 0; got = 1'b0;
        while (!got && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (!busy_o) busy_low++;
            if (ready_o) got = 1'b1;
        end
        chk({nm, "_ready_seen"}, 64'(got), 64'd1);
        chk({nm, "_latency"}, 64'(k), 64'(lat));
        chk({nm, "_busy_hold"}, 64'(busy_low), 64'd0);
        chk({nm, "_result"}, result_o, exp);
        chk({nm, "_rd"}, 64'(reg_waddr_o), 64'(rd));
        chk({nm, "_we"}, 64'(reg_we_o), 64'(got));
        $display("op=%b w=%0d a=%h b=%h rd=%0d res=%h exp=%h lat=%0d %s",
                 op, word, a, b, rd, result_o, exp, k, nm);
        last_res = exp;
        last_rd  = rd;
        @(posedge clk);
        #1;
        chk({nm, "_ready_pulse"}, 64'(ready_o), 64'd0);
        chk({nm, "_busy_drop"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int pulses;
        logic [2:0]  rop;
        logic        rw;
        logic [63:0] ra, rb;
        int sel;

        rst = 1'b1; start_i = 1'b0; op_i = 3'b0; word_i = 1'b0;
        dividend_i = '0; divisor_i = '0; reg_waddr_i = '0; flush_i = 1'b0;
        last_res = '0; last_rd = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_we", 64'(reg_we_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_rd", 64'(reg_waddr_o), 64'd0);
        rst = 1'b0;

        add_vec("divu_100_7",  3'b101, 1'b0, 64'd100, 64'd7, 64'd14);
        add_vec("remu_100_7",  3'b111, 1'b0, 64'd100, 64'd7, 64'd2);
        add_vec("div_m100_7",  3'b100, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2);
        add_vec("rem_m100_7",  3'b110, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        add_vec("rem_100_m7",  3'b110, 1'b0, 64'd100, -64'sd7, 64'd2);
        add_vec("div_by0",     3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("remu_by0",    3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234);
        add_vec("div_ovf",     3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000);
        add_vec("rem_ovf",     3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        add_vec("divw_ovf",    3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_8000_0000);
        add_vec("divuw_hi",    3'b101, 1'b1, 64'hABCD_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF);
        add_vec("remuw_16",    3'b111, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF);
        add_vec("remw_m7_2",   3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hDEAD_0000_0000_0002,
                64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("divw_m7_2",   3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hDEAD_0000_0000_0002,
                64'hFFFF_FFFF_FFFF_FFFD);
        add_vec("op000_divu",  3'b000, 1'b0, 64'd100, 64'd7, 64'd14);
        add_vec("divuw_sext",  3'b101, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        add_vec("remw_by0",    3'b110, 1'b1, 64'h5555_0000_8000_0005, 64'hFFFF_0000_0000_0000,
                64'hFFFF_FFFF_8000_0005);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                   5'(i + 1), vecs[i].exp);

        // Flush at CALC cycle 10: no ready, busy drops, result holds, next op correct
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b100; word_i = 1'b0;
        dividend_i = 64'd1000; divisor_i = 64'd3; reg_waddr_i = 5'd30;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_ready", 64'(ready_o), 64'd0);
        chk("flush_result_hold", result_o, last_res);
        chk("flush_rd_hold", 64'(reg_waddr_o), 64'(last_rd));
        pulses = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (ready_o) pulses++;
        end
        chk("flush_no_ready", 64'(pulses), 64'd0);
        $display("flush sequence: ready pulses after flush=%0d", pulses);
        run_op("after_flush", 3'b101, 1'b0, 64'd1000, 64'd3, 5'd29, 64'd333);

        // Flush in the DONE cycle still shows ready that cycle
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b111; word_i = 1'b0;
        dividend_i = 64'h77; divisor_i = 64'd0; reg_waddr_i = 5'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("done_flush_ready_pre", 64'(ready_o), 64'd1);
        flush_i = 1'b1;
        #1;
        chk("done_flush_ready", 64'(ready_o), 64'd1);
        chk("done_flush_result", result_o, 64'h77);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("done_flush_after", 64'(ready_o), 64'd0);
        $display("done+flush sequence: result=%h", result_o);

        // Reset mid-CALC clears every output
        @(negedge clk);
        start_i = 1'b1; op_i = 3'b101; word_i = 1'b0;
        dividend_i = 64'd12345; divisor_i = 64'd11; reg_waddr_i = 5'd17;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_calc_busy", 64'(busy_o), 64'd0);
        chk("rst_calc_ready", 64'(ready_o), 64'd0);
        chk("rst_calc_we", 64'(reg_we_o), 64'd0);
        chk("rst_calc_result", result_o, 64'd0);
        chk("rst_calc_rd", 64'(reg_waddr_o), 64'd0);
        $display("reset mid-calc: busy=%0d ready=%0d result=%h", busy_o, ready_o, result_o);
        run_op("after_rst", 3'b101, 1'b0, 64'd12345, 64'd11, 5'd17, 64'd1122);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 3'b100 | 3'($urandom_range(0, 3));
            rw  = 1'($urandom);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = rw ? {32'($urandom), 32'b0} : 64'b0;
            if (sel == 1) rb = 64'hFFFF_FFFF_FFFF_FFFF;
            if (sel == 2) begin
                ra = rw ? {32'($urandom), 32'h8000_0000} : 64'h8000_0000_0000_0000;
                rb = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            if (sel == 3) rb = 64'($urandom_range(1, 300));
            if (sel == 4) ra = 64'($urandom_range(0, 5000));
            run_op($sformatf("rand%0d", n), rop, rw, ra, rb, 5'($urandom), ref_div(rop, rw, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative multi-cycle divider inside the EX stage of the RV64IM pipeline.
- Consumes the operands and rd produced by instruction decode for DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW.
- Raises busy_o so the pipeline control logic holds IF/ID/EX until the result is ready.
- Returns a 64-bit result plus register write-back info for the EX/MEM path.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start_i  input  1  request a division; sampled only in IDLE.
op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other values treated as DIVU.
word_i  input  1  1 = W variant (opcode INST_TYPE_R_M_64W).
dividend_i  input  64  operand 1 (rs1 value).
divisor_i  input  64  operand 2 (rs2 value).
reg_waddr_i  input  5  destination rd.
flush_i  input  1  abort the current operation (branch/trap flush).
busy_o  output  1  high from the start acceptance cycle until the cycle ready_o is high, inclusive.
ready_o  output  1  one-cycle pulse; result_o is valid.
result_o  output  64  quotient or remainder.
reg_we_o  output  1  equal to ready_o.
reg_waddr_o  output  5  latched rd; valid while ready_o is high.

Behaviour:
- Reset: state=IDLE. busy_o, ready_o, reg_we_o, result_o and reg_waddr_o are all 0.
- Reset overrides flush and start.
- States and transitions:
  - IDLE: on start_i && !flush_i, latch op, word, rd, and |dividend|/|divisor| (magnitudes only for signed ops). Go to ZERO if the effective divisor is 0, else to CALC. busy_o = start_i.
  - CALC: one restoring step per cycle, using a shift of {rem,quot} and a trial subtract.
    - Iteration counter N = 64, or 32 when word_i.
    - After N steps go to DONE.
  - ZERO: go to DONE with quotient = all ones and remainder = the effective dividend.
  - DONE: ready_o=1 and reg_we_o=1 for exactly one cycle, then return to IDLE.
- Latency: if start is accepted at edge t0, ready_o is high in the cycle after edge t0+N+1. Divide-by-zero takes 2 cycles.
- Back-to-back: a new start is accepted in the cycle after DONE. start_i is ignored while not in IDLE.
- Effective operands:
  - word_i=0: full 64 bits.
  - word_i=1: low 32 bits, sign-extended for DIVW/REMW, zero-extended for DIVUW/REMUW. Upper bits are ignored.
- Sign fix-up for signed ops, applied in DONE:
  - Quotient is negated when the operand signs differ and the divisor is non-zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones; remainder = dividend (the effective one).
- Overflow (most-negative / -1): quotient = most-negative, remainder = 0. Must hold for both widths.
- Word result: result_o = sign-extension of bit 31 of the 32-bit result, for all four W ops, unsigned ones included.
- result_o and reg_waddr_o hold their last value outside DONE.
- Flush: flush_i in any state returns to IDLE at the next edge. No ready_o is produced. busy_o drops in the following cycle.
- Flush coinciding with DONE: ready_o still asserts that cycle; the write-back stage gates it.
- Operand inputs may change after acceptance without affecting the result.

Decomposition:
- Shared defines.v: INST_DIV/DIVU/REM/REMU funct3 codes, INST_TYPE_R_M_64W, RegBus, RegAddrBus, ZeroWord, WriteEnable.
- State encoding (IDLE, CALC, ZERO, DONE) is a local parameter set.
- No sub-module; the restoring-step datapath stays inline.

Test Plan:
- DIVU 100/7, word_i=0 -> ready_o at 65 cycles after acceptance; result 14. REMU -> 2; busy_o high throughout.
- DIV -100/7 -> -14 (0xFFFF_FFFF_FFFF_FFF2); REM -100/7 -> -2; REM 100/-7 -> 2.
- DIV x/0 -> all ones after 2 cycles; REMU 0x1234/0 -> 0x1234.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0. DIVW 0x8000_0000 / -1 -> 0xFFFF_FFFF_8000_0000.
- DIVUW with dividend 0xABCD_0000_FFFF_FFFE and divisor 2 -> ready after 33 cycles; result 0x7FFF_FFFF. REMUW with dividend 0xFFFF_FFFF and divisor 0x10 -> 0xF.
- Flush at CALC cycle 10 -> IDLE next edge, no ready_o; the next start is accepted and gives the correct result. rst asserted mid-CALC -> all outputs 0 next cycle.
